// File: rtl/rr_arbiter_4_pkg.sv
// rr_arbiter_4_pkg: shared constants for the four-way round-robin arbiter.
// FSM encoding and index sizing used by the arbiter, its picker and its bus.
package rr_arbiter_4_pkg;

  localparam int NUM_REQ = 4;
  localparam int IDX_W   = 2;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_GAP  = 2'd2;

endpackage

// File: rtl/rr_arbiter_4_if.sv
// rr_arbiter_4_if: request/grant bundle between the requesters and the arbiter.
// rel is the one-cycle "done" pulse from the currently granted unit.
interface rr_arbiter_4_if;
  import rr_arbiter_4_pkg::*;

  logic               en;
  logic [NUM_REQ-1:0] req;
  logic               rel;
  logic [IDX_W-1:0]   gnt_idx;
  logic               gnt_vld;
  logic               preempt;

  modport master (
    output en, req, rel,
    input  gnt_idx, gnt_vld, preempt
  );

  modport slave (
    input  en, req, rel,
    output gnt_idx, gnt_vld, preempt
  );

endinterface

// File: rtl/rr_arbiter_4_pick.sv
// rr_pick4: rotating priority search over four request lines.
// Highest priority is ptr, then ptr+1, ptr+2, ptr+3 with 2-bit wrap.
module rr_pick4
  import rr_arbiter_4_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [IDX_W-1:0]   win,
  output logic               any_req
);

  logic [2*NUM_REQ-1:0] dbl;
  logic [NUM_REQ-1:0]   rot;
  logic [IDX_W-1:0]     off;

  // rotate so ptr lands at bit 0, then take the first set bit
  always_comb begin
    dbl     = {req, req};
    rot     = dbl[ptr +: NUM_REQ];
    any_req = |req;
    off     = '0;
    priority case (1'b1)
      rot[0]:  off = 2'd0;
      rot[1]:  off = 2'd1;
      rot[2]:  off = 2'd2;
      rot[3]:  off = 2'd3;
      default: off = 2'd0;
    endcase
    win = ptr + off;
  end

endmodule

// File: rtl/rr_arbiter_4.sv
// rr_arbiter_4: registered round-robin arbiter with bounded hold time.
// Grants are separated by one idle cycle so the downstream one-hot is glitch-free.
module rr_arbiter_4
  import rr_arbiter_4_pkg::*;
#(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  rr_arbiter_4_if.slave bus
);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  logic [1:0]       state_q, state_d;
  logic [IDX_W-1:0] gnt_idx_q, gnt_idx_d;
  logic             gnt_vld_q, gnt_vld_d;
  logic             preempt_q, preempt_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] hold_q, hold_d;

  logic [IDX_W-1:0] win;
  logic             any_req;
  logic             norm_exit;
  logic             cap_exit;

  rr_pick4 u_pick (
    .req     (bus.req),
    .ptr     (ptr_q),
    .win     (win),
    .any_req (any_req)
  );

  // exit causes while a grant is live
  always_comb begin
    norm_exit = !bus.en || bus.rel || !bus.req[gnt_idx_q];
    cap_exit  = (hold_q == HOLD_LAST);
  end

  // next-state: arbitrate in IDLE/GAP, hold and release in BUSY
  always_comb begin
    state_d   = state_q;
    gnt_idx_d = gnt_idx_q;
    gnt_vld_d = gnt_vld_q;
    preempt_d = 1'b0;
    ptr_d     = ptr_q;
    hold_d    = hold_q;
    unique case (state_q)
      ST_BUSY: begin
        if (norm_exit || cap_exit) begin
          state_d   = ST_GAP;
          gnt_vld_d = 1'b0;
          ptr_d     = gnt_idx_q + 2'd1;
          preempt_d = cap_exit && !norm_exit;
        end else if (hold_q != HOLD_LAST) begin
          hold_d = hold_q + 1'b1;
        end
      end
      ST_IDLE, ST_GAP: begin
        state_d = ST_IDLE;
        if (bus.en && any_req) begin
          state_d   = ST_BUSY;
          gnt_idx_d = win;
          gnt_vld_d = 1'b1;
          hold_d    = '0;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        gnt_vld_d = 1'b0;
      end
    endcase
  end

  // state and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      gnt_idx_q <= '0;
      gnt_vld_q <= 1'b0;
      preempt_q <= 1'b0;
      ptr_q     <= '0;
      hold_q    <= '0;
    end else begin
      state_q   <= state_d;
      gnt_idx_q <= gnt_idx_d;
      gnt_vld_q <= gnt_vld_d;
      preempt_q <= preempt_d;
      ptr_q     <= ptr_d;
      hold_q    <= hold_d;
    end
  end

  assign bus.gnt_idx = gnt_idx_q;
  assign bus.gnt_vld = gnt_vld_q;
  assign bus.preempt = preempt_q;

endmodule

// File: tb/tb_rr_arbiter_4.sv
// tb_rr_arbiter_4: directed and random checks of the round-robin arbiter.
// Expected outputs come from a grant-level model of the arbitration rules.
module tb_rr_arbiter_4;
  import rr_arbiter_4_pkg::*;

  localparam int MH = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rr_arbiter_4_if bus();

  rr_arbiter_4 #(
    .MAX_HOLD (MH),
    .CNT_W    (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int vectors = 0;
  int miscompares = 0;

  bit m_vld;
  bit m_pre;
  int m_idx;
  int m_ptr;
  int m_held;

  task automatic model_reset();
    m_vld  = 0;
    m_pre  = 0;
    m_idx  = 0;
    m_ptr  = 0;
    m_held = 0;
  endtask

  task automatic model_edge(input bit en, input logic [3:0] req, input bit rel);
    bit normal;
    bit cap;
    m_pre = 0;
    if (m_vld) begin
      normal = !en || rel || !req[m_idx];
      cap    = (m_held == MH);
      if (normal || cap) begin
        m_vld = 0;
        m_ptr = (m_idx + 1) % 4;
        m_pre = cap && !normal;
      end else begin
        m_held++;
      end
    end else if (en && req != 4'b0) begin
      for (int k = 0; k < 4; k++) begin
        if (!m_vld && req[(m_ptr + k) % 4]) begin
          m_vld  = 1;
          m_idx  = (m_ptr + k) % 4;
          m_held = 1;
        end
      end
    end
  endtask

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".vld"}, {3'b0, bus.gnt_vld}, {3'b0, m_vld});
    chk({tag, ".idx"}, {2'b0, bus.gnt_idx}, 4'(m_idx));
    chk({tag, ".pre"}, {3'b0, bus.preempt}, {3'b0, m_pre});
  endtask

  task automatic step(input string tag, input bit en, input logic [3:0] req, input bit rel);
    bus.en  = en;
    bus.req = req;
    bus.rel = rel;
    @(posedge clk);
    model_edge(en, req, rel);
    #1;
    check_all(tag);
  endtask

  initial begin
    bus.en  = 1'b1;
    bus.req = 4'b0;
    bus.rel = 1'b0;
    model_reset();
    #2;
    check_all("rst");
    #10 rst_n = 1'b1;

    repeat (10) step("idle", 1, 4'b0000, 0);

    step("single", 1, 4'b0100, 0);
    chk("single.idx2", {2'b0, bus.gnt_idx}, 4'd2);
    step("single", 1, 4'b0100, 0);
    step("single", 1, 4'b0100, 0);
    step("single.rel", 1, 4'b0100, 1);
    chk("single.gap", {3'b0, bus.gnt_vld}, 4'd0);
    step("ptr3", 1, 4'b1111, 0);
    chk("ptr3.idx", {2'b0, bus.gnt_idx}, 4'd3);
    step("ptr3.rel", 1, 4'b1111, 1);

    for (int i = 0; i < 5; i++) begin
      step("rot", 1, 4'b1111, 0);
      chk("rot.seq", {2'b0, bus.gnt_idx}, 4'(i % 4));
      step("rot.rel", 1, 4'b1111, 1);
      chk("rot.gap", {3'b0, bus.gnt_vld}, 4'd0);
    end

    step("hold", 1, 4'b0001, 0);
    repeat (7) step("hold", 1, 4'b0001, 0);
    chk("hold.8th", {3'b0, bus.gnt_vld}, 4'd1);
    step("hold.exp", 1, 4'b0001, 0);
    chk("hold.pre", {3'b0, bus.preempt}, 4'd1);
    step("hold.regrant", 1, 4'b0001, 0);
    chk("hold.regrant", {3'b0, bus.gnt_vld}, 4'd1);

    repeat (7) step("coin", 1, 4'b0001, 0);
    step("coin.rel", 1, 4'b0001, 1);
    chk("coin.nopre", {3'b0, bus.preempt}, 4'd0);

    step("ar.grant", 1, 4'b1000, 0);
    chk("ar.idx3", {2'b0, bus.gnt_idx}, 4'd3);
    #3 rst_n = 1'b0;
    model_reset();
    #1;
    check_all("ar.async");
    #2 rst_n = 1'b1;
    repeat (3) step("ar.en0", 0, 4'b1000, 0);
    step("ar.en1", 1, 4'b1000, 0);
    chk("ar.en1.idx", {2'b0, bus.gnt_idx}, 4'd3);
    step("abort", 0, 4'b1000, 0);

    for (int i = 0; i < 3000; i++) begin
      logic [3:0] r;
      r = 4'($urandom);
      if (i % 500 > 250) r = r | 4'($urandom_range(1, 15));
      step("rand", ($urandom % 8) != 0, r, ($urandom % 7) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/rr_arbiter_4.md
Name: rr_arbiter_4

Overview:
- Four-requester round-robin arbiter. Produces a registered 2-bit grant index plus a valid flag.
- Sits directly upstream of the 2-to-4 decoder. gnt_idx drives the decoder's select input, and the decoder turns it into the one-hot enable for the granted unit.
- Enforces a fair rotating priority, a bounded hold time per grant, and a one-cycle idle gap between grants, so the downstream one-hot never changes mid-grant.

Parameters:
- MAX_HOLD, 8: maximum consecutive cycles one grant may be held before forced preemption; legal range 1..2**CNT_W.
- CNT_W, 4: width of the hold counter.

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  asynchronous, active-low reset.
- en  input  1  arbitration enable; low aborts any grant.
- req  input  4  request vector, bit i = requester i, level-sensitive.
- release  input  1  one-cycle pulse from the granted unit: done, drop the grant.
- gnt_idx  output  2  registered index of the granted requester; feeds the decoder select.
- gnt_vld  output  1  high while gnt_idx is a live grant.
- preempt  output  1  one-cycle pulse when a grant is ended by MAX_HOLD expiry.

Behaviour:
- Reset, async on rst_n low: state=IDLE, gnt_idx=2'b00, gnt_vld=0, preempt=0, ptr=2'b00, hold_cnt=0. All outputs are registered; nothing is combinational from inputs.
- ptr is the highest-priority index. Search order is ptr, ptr+1, ptr+2, ptr+3, all mod 4 (2-bit wrap, 3→0).
- States: IDLE, BUSY, GAP.
- IDLE:
  - If en=1 and req!=0: pick the first set bit in search order. Next cycle gnt_idx=winner, gnt_vld=1, hold_cnt=0, go BUSY. Latency from req sampled to gnt_vld high is 1 cycle.
  - Otherwise stay in IDLE with gnt_vld=0. gnt_idx keeps its last value.
- BUSY: hold_cnt increments each cycle, saturating at MAX_HOLD-1. Exit conditions, any of:
  - (a) en=0
  - (b) release=1
  - (c) req[gnt_idx]=0
  - (d) hold_cnt==MAX_HOLD-1
- On exit: next cycle gnt_vld=0, go GAP, ptr=gnt_idx+1 (mod 4). preempt=1 for that single cycle only if (d) is the sole cause.
- Exit priority when several causes coincide: en=0 / release / req drop all count as normal exit and suppress preempt. ptr advances in every case.
- GAP: gnt_vld=0 for exactly one cycle, then IDLE. The minimum spacing between two grants is therefore 1 low cycle; the earliest new gnt_vld is 2 cycles after the last high cycle.
- gnt_idx is stable for the entire time gnt_vld=1.
- MAX_HOLD=1: every grant lasts exactly 1 cycle. preempt pulses whenever no other exit cause is present.
- A req bit that rises during BUSY has no effect until the next IDLE evaluation.
- en=0 in IDLE or GAP: no grant is issued. ptr is unchanged.
- Reset asserted mid-grant: outputs clear immediately (async). After rst_n rises, the first arbitration starts from ptr=0.
- Widths: ptr and gnt_idx wrap naturally in 2 bits. hold_cnt compare is done at CNT_W bits.

Decomposition:
- Shared package holds:
  - state encoding localparams ST_IDLE=2'd0, ST_BUSY=2'd1, ST_GAP=2'd2;
  - NUM_REQ=4;
  - IDX_W=2.
- One sub-module is natural: rr_pick4, purely combinational. It rotates req by ptr, does a priority-find, and returns winner index and any_req. The FSM, counter and output registers stay in rr_arbiter_4.

Test Plan:
1. Reset and idle: rst_n=0 then 1, req=0, en=1 → gnt_vld=0, gnt_idx=0, preempt=0 for 10 cycles.
2. Single request, normal finish: req=4'b0100 at cycle 0 → gnt_idx=2, gnt_vld=1 from cycle 1; release pulse at cycle 3 → gnt_vld=0 at cycle 4 (GAP), ptr=3, preempt=0.
3. Round-robin rotation: req=4'b1111 held; each grant dropped by release after 1 cycle → gnt_idx sequence 0,1,2,3,0, with exactly one gnt_vld=0 cycle between grants.
4. Preemption: MAX_HOLD=8, req=4'b0001 held, no release → gnt_vld high for exactly 8 cycles, then preempt=1 for 1 cycle, then a new grant to index 0 two cycles after the last high cycle (only requester).
5. Coincident exit: in BUSY, release=1 on the same cycle hold_cnt==MAX_HOLD-1 → gnt_vld drops, preempt stays 0.
6. Async reset mid-grant and en abort: gnt_vld=1 with gnt_idx=3, rst_n pulled low between clock edges → gnt_vld=0 and gnt_idx=0 before the next edge; after rst_n releases, en=0 with req=4'b1000 → no grant until en=1, then gnt_idx=3 one cycle later.
